// File: rtl/program_sequencer.sv
// Program store and replay sequencer: captures words from the switches, then
// feeds them to the processor's external data bus one consume at a time.
module program_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [9:0]    Switches,
  input  logic          Enter,
  input  logic          Run,
  input  logic          Clear,
  input  logic          IRin,
  input  logic          Ext,
  input  logic          Clr,
  output logic [9:0]    Data,
  output logic          ProcEn,
  output logic          Done,
  output logic          Full,
  output logic [CW-1:0] Count,
  output logic [CW-1:0] Ptr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count_n, ptr_n;
  logic          done_n;
  logic          we_c;
  logic          consume_c;
  logic          last_c;
  logic [9:0]    mem [DEPTH];

  assign consume_c = IRin | Ext;
  assign last_c    = (Ptr == Count - CW'(1));

  assign Full   = (Count == CW'(DEPTH));
  assign ProcEn = (state == RUN) || (state == DRAIN);
  assign Data   = ProcEn ? mem[Ptr[AW-1:0]] : 10'd0;

  // Program memory is deliberately not reset; Count defines the valid region.
  always_ff @(posedge Clock) begin
    if (we_c) begin
      mem[Count[AW-1:0]] <= Switches;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Count <= '0;
      Ptr   <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      Count <= count_n;
      Ptr   <= ptr_n;
      Done  <= done_n;
    end
  end

  // Clear overrides every state action.
  always_comb begin
    state_n = state;
    count_n = Count;
    ptr_n   = Ptr;
    done_n  = Done;
    we_c    = 1'b0;
    if (Clear) begin
      state_n = IDLE;
      count_n = '0;
      ptr_n   = '0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Enter) begin
            if (!Full) begin
              we_c    = 1'b1;
              count_n = Count + CW'(1);
              done_n  = 1'b0;
            end
          end else if (Run && (Count != '0)) begin
            ptr_n   = '0;
            done_n  = 1'b0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (consume_c) begin
            if (!last_c) begin
              ptr_n = Ptr + CW'(1);
            end else if (Clr) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (Clr) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a 4-word store.
module tb_program_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          Clock = 1'b0;
  logic          Reset, Enter, Run, Clear, IRin, Ext, Clr;
  logic [9:0]    Switches;
  logic [9:0]    Data;
  logic          ProcEn, Done, Full;
  logic [CW-1:0] Count, Ptr;

  int n_checks = 0;
  int n_fail   = 0;

  program_sequencer #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Switches(Switches), .Enter(Enter),
    .Run(Run), .Clear(Clear), .IRin(IRin), .Ext(Ext), .Clr(Clr),
    .Data(Data), .ProcEn(ProcEn), .Done(Done), .Full(Full),
    .Count(Count), .Ptr(Ptr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then release them; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic en, input logic rn, input logic cl, input logic ir,
                     input logic ex, input logic cr, input logic [9:0] sw);
    Enter = en; Run = rn; Clear = cl; IRin = ir; Ext = ex; Clr = cr; Switches = sw;
    @(posedge Clock); #1;
    Enter = 0; Run = 0; Clear = 0; IRin = 0; Ext = 0; Clr = 0; Switches = '0;
  endtask

  task automatic enter(input logic [9:0] sw);
    cyc(1, 0, 0, 0, 0, 0, sw);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".data"},   32'(Data),   32'h0);
    check({tag, ".procen"}, 32'(ProcEn), 32'h0);
    check({tag, ".done"},   32'(Done),   32'h0);
    check({tag, ".full"},   32'(Full),   32'h0);
    check({tag, ".count"},  32'(Count),  32'h0);
    check({tag, ".ptr"},    32'(Ptr),    32'h0);
  endtask

  initial begin
    Reset = 1; Enter = 0; Run = 0; Clear = 0; IRin = 0; Ext = 0; Clr = 0; Switches = '0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 0;
    check_reset_vals("reset");

    // Run with an empty program is ignored
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("empty_run.procen", 32'(ProcEn), 32'h0);

    // Entry up to full, then an overflow attempt
    enter(10'h000);
    check("entry1.count", 32'(Count), 32'h1);
    enter(10'h005);
    enter(10'h203);
    enter(10'h112);
    check("entry4.count", 32'(Count), 32'h4);
    check("entry4.full",  32'(Full),  32'h1);
    enter(10'h3FF);
    check("overflow.count", 32'(Count), 32'h4);
    check("overflow.full",  32'(Full),  32'h1);

    // Replay all four words; the last must still be 0x112
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("full_run.procen", 32'(ProcEn), 32'h1);
    check("full_run.w0",     32'(Data),   32'h000);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("full_run.w1",     32'(Data),   32'h005);
    cyc(0, 0, 0, 0, 1, 0, '0);
    check("full_run.w2",     32'(Data),   32'h203);
    cyc(0, 0, 0, 1, 1, 0, '0);
    check("both_consume.ptr", 32'(Ptr),   32'h3);
    check("full_run.w3",     32'(Data),   32'h112);
    cyc(0, 0, 0, 1, 0, 1, '0);
    check("full_run.end_procen", 32'(ProcEn), 32'h0);
    check("full_run.end_done",   32'(Done),   32'h1);
    check("full_run.end_ptr",    32'(Ptr),    32'h3);
    check("full_run.end_data",   32'(Data),   32'h0);

    // Replay with a separate final Clr (passes through DRAIN)
    cyc(0, 0, 1, 0, 0, 0, '0);
    check("clear.count", 32'(Count), 32'h0);
    check("clear.done",  32'(Done),  32'h0);
    enter(10'h000);
    enter(10'h005);
    enter(10'h203);
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("replay.irin_data", 32'(Data), 32'h000);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("replay.ext_data",  32'(Data), 32'h005);
    cyc(0, 0, 0, 0, 1, 0, '0);
    check("replay.irin2_data", 32'(Data), 32'h203);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("drain.procen", 32'(ProcEn), 32'h1);
    check("drain.ptr",    32'(Ptr),    32'h2);
    check("drain.done",   32'(Done),   32'h0);
    cyc(0, 0, 0, 0, 1, 0, '0);
    check("drain.consume_ignored", 32'(Ptr), 32'h2);
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("drain.run_ignored", 32'(ProcEn), 32'h1);
    cyc(0, 0, 0, 0, 0, 1, '0);
    check("replay.end_procen", 32'(ProcEn), 32'h0);
    check("replay.end_done",   32'(Done),   32'h1);
    check("replay.end_ptr",    32'(Ptr),    32'h2);

    // Enter after completion appends and clears Done
    enter(10'h111);
    check("append.count", 32'(Count), 32'h4);
    check("append.done",  32'(Done),  32'h0);

    // Single-word program, final consume and Clr together
    cyc(0, 0, 1, 0, 0, 0, '0);
    enter(10'h000);
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("single.procen", 32'(ProcEn), 32'h1);
    cyc(0, 0, 0, 0, 1, 1, '0);
    check("single.end_procen", 32'(ProcEn), 32'h0);
    check("single.end_done",   32'(Done),   32'h1);

    // Enter and Run together: Enter wins
    cyc(1, 1, 0, 0, 0, 0, 10'h0A1);
    check("enter_run.count",  32'(Count),  32'h2);
    check("enter_run.procen", 32'(ProcEn), 32'h0);

    // Abort during DRAIN
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("abort.w0", 32'(Data), 32'h000);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("abort.w1", 32'(Data), 32'h0A1);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("abort.in_drain", 32'(ProcEn), 32'h1);
    cyc(0, 0, 1, 0, 0, 0, '0);
    check("abort.procen", 32'(ProcEn), 32'h0);
    check("abort.count",  32'(Count),  32'h0);
    check("abort.done",   32'(Done),   32'h0);
    check("abort.data",   32'(Data),   32'h0);
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("abort.run_ignored", 32'(ProcEn), 32'h0);

    // Reset mid-run
    enter(10'h2AA);
    enter(10'h155);
    cyc(0, 1, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, '0);
    check("midrun.data", 32'(Data), 32'h155);
    Reset = 1;
    @(posedge Clock); #1;
    Reset = 0;
    check_reset_vals("midrun_reset");
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("midrun_reset.run_ignored", 32'(ProcEn), 32'h0);
    enter(10'h3C3);
    cyc(0, 1, 0, 0, 0, 0, '0);
    check("midrun_reset.rerun_procen", 32'(ProcEn), 32'h1);
    check("midrun_reset.rerun_data",   32'(Data),   32'h3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
